// File: rtl/al422_bam_pkg.sv
// Shared state encoding and width helpers for the AL422 BAM row scheduler.
package al422_bam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_GO,
    S_SHIFT_WAIT,
    S_OE_WAIT,
    S_LATCH,
    S_OE_GO,
    S_DRAIN,
    S_GHOST
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/al422_bam_pulse_timer.sv
// Load/countdown interval timer; done_o is high on the last clock of a loaded interval.
module al422_bam_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == W'(1));

endmodule

// File: rtl/al422_bam_row_scheduler.sv
// Frame sequencer for the BAM LED panel: shift, latch and OE per (row, plane).
// Optional anti-ghosting blank on row changes is enabled by BAM_SCHED_GHOST_BLANK_EN.
module al422_bam_row_scheduler
  import al422_bam_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int BITS        = 8,
  parameter int LATCH_WIDTH = 2,
  parameter int GHOST_DELAY = 4,
  localparam int ROW_W      = idx_width(ROWS),
  localparam int BIT_W      = idx_width(BITS)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             frame_start,
  output logic             shift_start,
  output logic [ROW_W-1:0] shift_row,
  output logic [BIT_W-1:0] shift_bit,
  input  logic             shift_busy,
  output logic             oe_start,
  output logic [BIT_W-1:0] oe_bit,
  input  logic             oe_busy,
  output logic             led_lat,
  output logic [ROW_W-1:0] led_row,
  output logic             frame_done,
  output logic             sched_busy
);

  localparam int TMR_W = idx_width(max2(LATCH_WIDTH, GHOST_DELAY) + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS - 1);

  sched_state_e     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BIT_W-1:0] oeBit_q, oeBit_d;
  logic [ROW_W-1:0] ledRow_q, ledRow_d;
  logic             pend_q, pend_d;
  logic             skip_q, skip_d;
  logic             tmrLoad;
  logic [TMR_W-1:0] tmrVal;
  logic             tmrDone;
  logic             frameDone;
`ifdef BAM_SCHED_GHOST_BLANK_EN
  logic             rowChg_q, rowChg_d;
`endif

  // Latch width and ghost blank never overlap, so one timer serves both.
  al422_bam_pulse_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i      (in_clk),
    .rst_i      (in_rst),
    .load_i     (tmrLoad),
    .load_val_i (tmrVal),
    .done_o     (tmrDone)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    bit_d     = bit_q;
    oeBit_d   = oeBit_q;
    ledRow_d  = ledRow_q;
    pend_d    = pend_q;
    skip_d    = 1'b0;
    tmrLoad   = 1'b0;
    tmrVal    = TMR_W'(LATCH_WIDTH);
    frameDone = 1'b0;
`ifdef BAM_SCHED_GHOST_BLANK_EN
    rowChg_d  = rowChg_q;
`endif

    if (frame_start && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start || pend_q) begin
          row_d   = '0;
          bit_d   = '0;
          pend_d  = 1'b0;
          state_d = S_SHIFT_GO;
        end
      end
      S_SHIFT_GO: begin
        skip_d  = 1'b1;
        state_d = S_SHIFT_WAIT;
      end
      S_SHIFT_WAIT: begin
        if (!skip_q && !shift_busy) begin
          state_d = S_OE_WAIT;
        end
      end
      S_OE_WAIT: begin
        if (!oe_busy) begin
          ledRow_d = row_q;
          tmrLoad  = 1'b1;
          state_d  = S_LATCH;
`ifdef BAM_SCHED_GHOST_BLANK_EN
          rowChg_d = (row_q != ledRow_q);
`endif
        end
      end
      S_LATCH: begin
        if (tmrDone) begin
`ifdef BAM_SCHED_GHOST_BLANK_EN
          if (rowChg_q && (GHOST_DELAY > 0)) begin
            tmrLoad = 1'b1;
            tmrVal  = TMR_W'(GHOST_DELAY);
            state_d = S_GHOST;
          end else begin
            state_d = S_OE_GO;
          end
`else
          state_d = S_OE_GO;
`endif
        end
      end
      S_GHOST: begin
        if (tmrDone) begin
          state_d = S_OE_GO;
        end
      end
      S_OE_GO: begin
        // Explicit wrap so non-power-of-two geometries never run past the last index.
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
          row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
        if ((row_q == LAST_ROW) && (bit_q == LAST_BIT)) begin
          skip_d  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          state_d = S_SHIFT_GO;
        end
      end
      S_DRAIN: begin
        if (!skip_q && !oe_busy) begin
          frameDone = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_OE_GO) begin
      oeBit_d = bit_q;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      bit_q    <= '0;
      oeBit_q  <= '0;
      ledRow_q <= '0;
      pend_q   <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      bit_q    <= bit_d;
      oeBit_q  <= oeBit_d;
      ledRow_q <= ledRow_d;
      pend_q   <= pend_d;
      skip_q   <= skip_d;
    end
  end

`ifdef BAM_SCHED_GHOST_BLANK_EN
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rowChg_q <= 1'b0;
    end else begin
      rowChg_q <= rowChg_d;
    end
  end
`endif

  assign shift_start = (state_q == S_SHIFT_GO);
  assign shift_row   = row_q;
  assign shift_bit   = bit_q;
  assign oe_start    = (state_q == S_OE_GO);
  assign oe_bit      = oeBit_q;
  assign led_lat     = (state_q == S_LATCH);
  assign led_row     = ledRow_q;
  assign frame_done  = frameDone;
  assign sched_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_al422_bam_row_scheduler.sv
// Self-checking bench for al422_bam_row_scheduler with randomized shifter/OE responders.
module tb_al422_bam_row_scheduler;

  localparam int ROWS        = 5;
  localparam int BITS        = 3;
  localparam int LATCH_WIDTH = 2;
  localparam int GHOST_DELAY = 4;
  localparam int ROW_W       = $clog2(ROWS);
  localparam int BIT_W       = (BITS > 1) ? $clog2(BITS) : 1;
`ifdef BAM_SCHED_GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  logic             in_clk;
  logic             in_rst;
  logic             frame_start;
  logic             shift_start;
  logic [ROW_W-1:0] shift_row;
  logic [BIT_W-1:0] shift_bit;
  logic             shift_busy;
  logic             oe_start;
  logic [BIT_W-1:0] oe_bit;
  logic             oe_busy;
  logic             led_lat;
  logic [ROW_W-1:0] led_row;
  logic             frame_done;
  logic             sched_busy;

  int compared   = 0;
  int mismatched = 0;

  int shMin = 1, shMax = 6, oeMin = 1, oeMax = 8;
  int shCnt = 0, oeCnt = 0;

  int shQ[$];
  int oeQ[$];
  int gapQ[$];
  int latLenQ[$];
  int lowQ[$];
  int doneCnt = 0, latOverlap = 0, overlap = 0;
  int cyc = 0, latRun = 0, latFall = 0, lowRun = 0;
  int doneBase = 0, latOverlapBase = 0, overlapBase = 0;
  int prevRow = 0;
  int found;

  al422_bam_row_scheduler #(
    .ROWS        (ROWS),
    .BITS        (BITS),
    .LATCH_WIDTH (LATCH_WIDTH),
    .GHOST_DELAY (GHOST_DELAY)
  ) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .frame_start (frame_start),
    .shift_start (shift_start),
    .shift_row   (shift_row),
    .shift_bit   (shift_bit),
    .shift_busy  (shift_busy),
    .oe_start    (oe_start),
    .oe_bit      (oe_bit),
    .oe_busy     (oe_busy),
    .led_lat     (led_lat),
    .led_row     (led_row),
    .frame_done  (frame_done),
    .sched_busy  (sched_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Shifter responder: busy for a random number of clocks starting the clock after shift_start.
  always @(posedge in_clk) begin
    if (in_rst) begin
      shift_busy <= 1'b0;
      shCnt      <= 0;
    end else if (shift_start) begin
      shift_busy <= 1'b1;
      shCnt      <= int'($urandom_range(shMax, shMin));
    end else if (shCnt > 1) begin
      shCnt <= shCnt - 1;
    end else begin
      shift_busy <= 1'b0;
      shCnt      <= 0;
    end
  end

  // OE responder with the same busy protocol.
  always @(posedge in_clk) begin
    if (in_rst) begin
      oe_busy <= 1'b0;
      oeCnt   <= 0;
    end else if (oe_start) begin
      oe_busy <= 1'b1;
      oeCnt   <= int'($urandom_range(oeMax, oeMin));
    end else if (oeCnt > 1) begin
      oeCnt <= oeCnt - 1;
    end else begin
      oe_busy <= 1'b0;
      oeCnt   <= 0;
    end
  end

  // Event logger sampled on the falling edge.
  always @(negedge in_clk) begin
    cyc <= cyc + 1;
    if (in_rst) begin
      latRun <= 0;
      lowRun <= 0;
    end else begin
      if (led_lat) begin
        latRun <= latRun + 1;
      end else if (latRun != 0) begin
        latLenQ.push_back(latRun);
        latRun  <= 0;
        latFall <= cyc;
      end
      if (shift_start) shQ.push_back(int'(shift_row) * 100 + int'(shift_bit));
      if (oe_start) begin
        oeQ.push_back(int'(led_row) * 100 + int'(oe_bit));
        if (latRun != 0) gapQ.push_back(0);
        else gapQ.push_back(cyc - latFall);
      end
      if (led_lat && oe_busy) latOverlap <= latOverlap + 1;
      if (shift_busy && oe_busy) overlap <= overlap + 1;
      if (frame_done) doneCnt <= doneCnt + 1;
      if (!sched_busy) begin
        lowRun <= lowRun + 1;
      end else if (lowRun != 0) begin
        lowQ.push_back(lowRun);
        lowRun <= 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic sampleTick();
    @(negedge in_clk);
    #1;
  endtask

  task automatic applyStimulus();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clearLogs();
    shQ.delete();
    oeQ.delete();
    gapQ.delete();
    latLenQ.delete();
    lowQ.delete();
    doneBase       = doneCnt;
    latOverlapBase = latOverlap;
    overlapBase    = overlap;
  endtask

  task automatic waitFrames(input int target, input int budget);
    for (int i = 0; (i < budget) && ((doneCnt - doneBase) < target); i++) sampleTick();
    checkOutput("frameDoneCount", doneCnt - doneBase, target);
  endtask

  // Reference: frames scan rows in order, planes in order, each latch LATCH_WIDTH long,
  // with a ghost blank only where the latched row differs from the previously latched one.
  task automatic checkFrameLog(input int nFrames);
    int n;
    int idx;
    int exp;
    int expGap;
    n = nFrames * ROWS * BITS;
    checkOutput("oeStartCount", oeQ.size(), n);
    checkOutput("shiftStartCount", shQ.size(), n);
    checkOutput("latchCount", latLenQ.size(), n);
    idx = 0;
    for (int f = 0; f < nFrames; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int b = 0; b < BITS; b++) begin
          exp    = r * 100 + b;
          expGap = (GHOST_EN && (r != prevRow)) ? GHOST_DELAY : 0;
          prevRow = r;
          if (idx < oeQ.size()) checkOutput("oeRowBit", oeQ[idx], exp);
          if (idx < shQ.size()) checkOutput("shiftRowBit", shQ[idx], exp);
          if (idx < gapQ.size()) checkOutput("latchToOeGap", gapQ[idx], expGap);
          if (idx < latLenQ.size()) checkOutput("latchWidth", latLenQ[idx], LATCH_WIDTH);
          idx++;
        end
      end
    end
  endtask

  initial begin
    in_rst      = 1'b1;
    frame_start = 1'b0;
    repeat (3) tick();
    sampleTick();
    checkOutput("resetOutputs",
                int'({shift_start, shift_row, shift_bit, oe_start, oe_bit,
                      led_lat, led_row, frame_done, sched_busy}), 0);
    tick();
    in_rst = 1'b0;
    tick();

    // Single frame with short random busy times.
    clearLogs();
    applyStimulus();
    sampleTick();
    checkOutput("schedBusyInFrame", int'(sched_busy), 1);
    waitFrames(1, 3000);
    sampleTick();
    checkOutput("schedBusyAfterDone", int'(sched_busy), 0);
    checkFrameLog(1);
    checkOutput("latchDuringOe", latOverlap - latOverlapBase, 0);

    // Long OE, fixed shifter: latch must wait for OE, shift must overlap OE.
    shMin = 5; shMax = 5; oeMin = 40; oeMax = 40;
    clearLogs();
    applyStimulus();
    waitFrames(1, 6000);
    checkFrameLog(1);
    checkOutput("latchDuringOeLong", latOverlap - latOverlapBase, 0);
    checkOutput("shiftOverlapsOe", int'((overlap - overlapBase) > 0), 1);

    // Three requests during a frame merge into one pending frame.
    shMin = 1; shMax = 6; oeMin = 1; oeMax = 8;
    clearLogs();
    applyStimulus();
    repeat (10) tick();
    lowQ.delete();
    applyStimulus();
    repeat (7) tick();
    applyStimulus();
    repeat (20) tick();
    applyStimulus();
    waitFrames(2, 6000);
    repeat (200) tick();
    checkOutput("framesAfterMerge", doneCnt - doneBase, 2);
    checkFrameLog(2);
    checkOutput("idleGapCount", lowQ.size(), 1);
    checkOutput("idleGapLen", (lowQ.size() > 0) ? lowQ[0] : -1, 1);

    // Request in the same clock as frame_done becomes pending.
    clearLogs();
    applyStimulus();
    repeat (5) tick();
    lowQ.delete();
    found = 0;
    for (int i = 0; (i < 3000) && (found == 0); i++) begin
      sampleTick();
      if (frame_done) found = 1;
    end
    checkOutput("frameDoneSeen", found, 1);
    if (found == 1) applyStimulus();
    waitFrames(2, 4000);
    repeat (200) tick();
    checkOutput("framesCoincident", doneCnt - doneBase, 2);
    checkFrameLog(2);
    checkOutput("coincidentGapLen", (lowQ.size() > 0) ? lowQ[0] : -1, 1);

    // Reset while latching row 2 aborts the frame; the next frame restarts at row 0.
    clearLogs();
    applyStimulus();
    found = 0;
    for (int i = 0; (i < 3000) && (found == 0); i++) begin
      sampleTick();
      if (led_lat && (led_row == ROW_W'(2))) found = 1;
    end
    checkOutput("latchRow2Seen", found, 1);
    in_rst = 1'b1;
    tick();
    checkOutput("outputsAfterMidReset",
                int'({shift_start, shift_row, shift_bit, oe_start, oe_bit,
                      led_lat, led_row, frame_done, sched_busy}), 0);
    tick();
    in_rst = 1'b0;
    prevRow = 0;
    tick();
    clearLogs();
    applyStimulus();
    waitFrames(1, 3000);
    checkOutput("firstShiftAfterReset", (shQ.size() > 0) ? shQ[0] : -1, 0);
    checkFrameLog(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
